cmp_seq_mag: RTL and testbench
==============================

// Module: cmp_seq_mag
// PURPOSE
//  Sequential unsigned magnitude comparator. Takes two WIDTH-bit operands on a start
//  strobe and compares them one bit per cycle, MSB first. Produces registered one-hot
//  aeb/agb/alb flags plus a one-cycle done pulse.
//  Area-lean alternative to the flat combinational comparators; sits beside them in the
//  compare datapath and feeds the same downstream consumers.
// PARAMETERS
//  WIDTH    8    operand width in bits, >=1
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  operand A, captured on the accepted start edge
//  b       in   WIDTH  operand B, captured on the accepted start edge
//  busy    out  1      high while a compare is in progress (RUN or DONE)
//  done    out  1      one-cycle pulse; result flags are valid in this cycle
//  aeb     out  1      a == b
//  agb     out  1      a > b
//  alb     out  1      a < b
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; busy=done=aeb=agb=alb=0; shift regs and counter=0.
//  - Reset mid-operation aborts the compare. All outputs return to 0. No done is issued.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: on an edge with start=1:
//      - load sa<=a and sb<=b, set cnt<=WIDTH-1, clear the decided flag;
//      - go to RUN; busy rises.
//  - RUN: each edge examines sa[MSB] vs sb[MSB] via cmp_bit_cell, then shifts sa/sb left
//    by 1 and decrements cnt.
//  - First differing bit decides the result: agb if a-bit=1, else alb.
//  - If cnt==0 and no difference has been found, the result is aeb.
//  - Result flags are registered on the edge that enters DONE.
//  - Flags stay exactly one-hot after the first completion.
//  - Flags hold their previous result through reset-free idle and busy periods.
//    They change only when entering DONE.
//  - DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 in DONE and drops in IDLE.
//  - start is ignored while busy (RUN/DONE); no queuing.
//  - If start is held high, a new compare is accepted on the first IDLE edge.
//    Minimum spacing between done pulses is k+2 cycles.
//  - Latency: k edges from the accepted start edge to the done cycle, where k = number of
//    bits examined (1..WIDTH).
//  - WIDTH=1: a single RUN edge, then DONE.
//  - Counter width: $clog2(WIDTH) with a minimum of 1. Unsigned compare only.
// CONFIGURATION
//  CMP_SEQ_EARLY_EXIT_EN
//   - defined: RUN terminates on the first differing bit, so k = WIDTH - (index of the
//     first differing bit from the MSB). k = WIDTH when the operands are equal.
//   - undefined: constant latency, k = WIDTH always. The first difference is latched into
//     a sticky decided flag and the remaining bits are shifted but ignored.
//   - Result values are identical in both builds; only latency differs.
// STRUCTURE
//  - Shared package cmp_pkg:
//      - state_t enum {IDLE, RUN, DONE};
//      - localparam CMP_RES_EQ/GT/LT 3-bit one-hot codes {aeb, agb, alb}.
//  - Sub-module cmp_bit_cell: combinational 1-bit compare (a, b -> eq, gt, lt).
//    Instantiated once on the shift-register MSBs.
//  - Top level: FSM, shift registers, counter, decided flag, output registers.
// TESTING (WIDTH=8)
//  1. Assert rst mid-run, release -> busy=done=aeb=agb=alb=0 immediately; next start works.
//  2. a=8'hA5, b=8'hA5, start -> done 8 edges later; aeb=1, agb=alb=0 (both builds).
//  3. a=8'h80, b=8'h7F -> agb=1. Latency 1 edge with EARLY_EXIT_EN defined, 8 without.
//  4. a=8'h03, b=8'h04 -> alb=1. Latency 6 edges (EN) / 8 (no EN).
//  5. Pulse start with a=8'h00/b=8'hFF during RUN of case 2 -> ignored; result still aeb=1.
//  6. start held high, alternating operands -> back-to-back dones spaced k+2 cycles.
//     Flags are one-hot at every done; flags hold between dones.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg
//   Shared definitions for the sequential magnitude comparator:
//   FSM state encoding, one-hot result codes {aeb, agb, alb} and a
//   helper that sizes the bit counter.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result codes, bit order {aeb, agb, alb}
  localparam logic [2:0] CMP_RES_NONE = 3'b000;
  localparam logic [2:0] CMP_RES_EQ   = 3'b100;
  localparam logic [2:0] CMP_RES_GT   = 3'b010;
  localparam logic [2:0] CMP_RES_LT   = 3'b001;

  // Counter width: $clog2(w), but never narrower than one bit
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// cmp_bit_cell
//   Combinational single-bit unsigned compare.
// Ports
//   a, b   in   operand bits
//   eq     out  a == b
//   gt     out  a > b  (a=1, b=0)
//   lt     out  a < b  (a=0, b=1)
module cmp_bit_cell
  import cmp_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = ~(a ^ b);
  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

// File: rtl/cmp_seq_mag.sv
// cmp_seq_mag
//   Sequential unsigned magnitude comparator. Operands are captured on an
//   accepted start, then compared one bit per cycle, MSB first. Registered
//   one-hot result flags {aeb, agb, alb} update only on entry to DONE, and
//   done pulses for one cycle while they are fresh.
// Parameters
//   WIDTH   operand width in bits (>= 1)
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   start   in   compare request, only honoured in IDLE
//   a, b    in   WIDTH-bit operands, captured on the accepted start edge
//   busy    out  high in RUN and DONE
//   done    out  one-cycle pulse, flags valid
//   aeb     out  a == b
//   agb     out  a > b
//   alb     out  a < b
// Configuration
//   CMP_SEQ_EARLY_EXIT_EN  defined: RUN ends on the first differing bit.
//                          undefined: always WIDTH RUN cycles; the first
//                          difference is held in a sticky decided flag.
module cmp_seq_mag
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeb,
  output logic             agb,
  output logic             alb
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic [2:0]       res;

  logic             bit_eq;
  logic             bit_gt;
  logic             bit_lt;
  logic [2:0]       bit_res;
  logic             last_bit;
  logic             finish;
  logic [2:0]       final_res;

  cmp_bit_cell u_cell (
    .a  (sa[WIDTH-1]),
    .b  (sb[WIDTH-1]),
    .eq (bit_eq),
    .gt (bit_gt),
    .lt (bit_lt)
  );

  assign bit_res  = bit_gt ? CMP_RES_GT : (bit_lt ? CMP_RES_LT : CMP_RES_EQ);
  assign last_bit = (cnt == '0);

`ifdef CMP_SEQ_EARLY_EXIT_EN
  // The bit under examination is the first unequal one whenever it differs,
  // since any earlier difference would already have ended RUN.
  assign finish    = !bit_eq || last_bit;
  assign final_res = bit_res;
`else
  logic       decided;
  logic [2:0] dec_res;

  // A difference seen earlier outranks whatever the lower bits say.
  assign finish    = last_bit;
  assign final_res = decided ? dec_res : bit_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decided <= 1'b0;
      dec_res <= CMP_RES_NONE;
    end else if (state == IDLE) begin
      if (start) begin
        decided <= 1'b0;
      end
    end else if (state == RUN) begin
      if (!decided && !bit_eq) begin
        decided <= 1'b1;
        dec_res <= bit_res;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, shift/count in RUN, result latched on the
  // RUN edge that enters DONE so flags hold everywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
      res <= CMP_RES_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            cnt <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          sa  <= sa << 1;
          sb  <= sb << 1;
          cnt <= cnt - 1'b1;
          if (finish) begin
            res <= final_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign {aeb, agb, alb} = res;

endmodule

// File: tb/tb_cmp_seq_mag.sv
module tb_cmp_seq_mag;

  localparam int W = 8;

`ifdef CMP_SEQ_EARLY_EXIT_EN
  localparam int LAT_80_7F = 1;
  localparam int LAT_03_04 = 6;
`else
  localparam int LAT_80_7F = 8;
  localparam int LAT_03_04 = 8;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         aeb;
  logic         agb;
  logic         alb;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  cmp_seq_mag #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .aeb   (aeb),
    .agb   (agb),
    .alb   (alb)
  );

  // Reference: number of bits examined for an operand pair
  function automatic int model_k(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef CMP_SEQ_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return W - i;
    end
`endif
    return W;
  endfunction

  // Reference: expected one-hot flags {aeb, agb, alb}
  function automatic logic [2:0] model_flags(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == y) return 3'b100;
    if (x > y)  return 3'b010;
    return 3'b001;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: cycles of busy remaining after each edge
  int         m_left;
  logic [2:0] m_flags;
  logic [2:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left  <= 0;
      m_flags <= 3'b000;
      m_pend  <= 3'b000;
    end else if (m_left == 0) begin
      if (start) begin
        m_left <= model_k(a, b) + 1;
        m_pend <= model_flags(a, b);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_flags <= m_pend;
    end
  end

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    checkOutput("busy", int'(busy), int'(m_left > 0));
    checkOutput("done", int'(done), int'(m_left == 1));
    checkOutput("flags", int'({aeb, agb, alb}), int'(m_flags));
    if (done) checkOutput("onehot", int'($onehot({aeb, agb, alb})), 1);
  end

  task automatic waitIdle();
    int g = 0;
    while (busy && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (busy) checkOutput("idle_timeout", 0, 1);
  endtask

  // One compare; returns edges from the accept edge to the done cycle.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input bit interfere, output int lat);
    waitIdle();
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (interfere && n == 2) begin
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
      end
      @(posedge clk); #1;
      if (interfere && n == 2) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) checkOutput("done_timeout", 0, 1);
  endtask

  logic [W-1:0] pa[4];
  logic [W-1:0] pb[4];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int prev_t;
    int g;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_flags", int'({done, aeb, agb, alb}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Equal operands
    applyStimulus(8'hA5, 8'hA5, 1'b0, lat);
    checkOutput("lat_a5", lat, 8);
    checkOutput("flags_a5", int'({aeb, agb, alb}), 3'b100);

    // Difference in the MSB
    applyStimulus(8'h80, 8'h7F, 1'b0, lat);
    checkOutput("lat_80_7f", lat, LAT_80_7F);
    checkOutput("flags_80_7f", int'({aeb, agb, alb}), 3'b010);

    // Difference at bit 2
    applyStimulus(8'h03, 8'h04, 1'b0, lat);
    checkOutput("lat_03_04", lat, LAT_03_04);
    checkOutput("flags_03_04", int'({aeb, agb, alb}), 3'b001);

    // Difference only in the LSB
    applyStimulus(8'hFF, 8'hFE, 1'b0, lat);
    checkOutput("lat_ff_fe", lat, 8);
    checkOutput("flags_ff_fe", int'({aeb, agb, alb}), 3'b010);

    // start pulsed mid-run with different operands is ignored
    applyStimulus(8'hA5, 8'hA5, 1'b1, lat);
    checkOutput("lat_ignore", lat, 8);
    checkOutput("flags_ignore", int'({aeb, agb, alb}), 3'b100);

    // Reset mid-run aborts and clears everything immediately
    waitIdle();
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_flags", int'({done, aeb, agb, alb}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    g = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) g++;
    end
    checkOutput("abort_no_done", g, 0);

    applyStimulus(8'h00, 8'h01, 1'b0, lat);
    checkOutput("post_rst_flags", int'({aeb, agb, alb}), 3'b001);

    // start held high: back-to-back compares spaced k+2 cycles
    pa = '{8'h80, 8'h03, 8'hA5, 8'h01};
    pb = '{8'h7F, 8'h04, 8'hA5, 8'h00};
    waitIdle();
    a = pa[0];
    b = pb[0];
    start = 1'b1;
    prev_t = 0;
    for (int i = 0; i < 4; i++) begin
      g = 0;
      do begin
        @(posedge clk); #1;
        g++;
      end while (!done && g < 40);
      if (!done) begin
        checkOutput("b2b_timeout", 0, 1);
        break;
      end
      if (i > 0) checkOutput("b2b_spacing", cyc - prev_t, model_k(pa[i], pb[i]) + 2);
      prev_t = cyc;
      if (i < 3) begin
        a = pa[i + 1];
        b = pb[i + 1];
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
